// File: rtl/led_frame_scheduler.sv
// Purpose: round-robin share of one serial LED shift chain between two word producers.
// Latency: word captured on a rising edge, its MSB and start appear on the next falling edge.
// Backpressure: req is held until the one-cycle ack; a new word is taken only once WIDTH bits are out.
module led_frame_scheduler #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   output logic             ack0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             ack1,
   output logic             sdo,
   output logic             start,
   output logic             str,
   output logic             busy,
   output logic             grant_id
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             last_q, last_d;
   logic             grant_id_q, grant_id_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             sdo_q, sdo_d;
   logic             start_q, start_d;
   logic             str_q, str_d;

   logic cap_opp;
   logic grant0;
   logic grant1;

   // Next-state: flush wins, then capture/arbitration at frame boundary, else shift one bit.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      last_d     = last_q;
      grant_id_d = grant_id_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;

      // Capturing on the last bit keeps frames back-to-back with no idle cycle.
      cap_opp = (state_q == IDLE) || (cnt_q == CNT_LAST);
      // On a tie the requester that was not granted last time wins.
      grant0  = req0 && (!req1 || last_q);
      grant1  = req1 && (!req0 || !last_q);

      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (cap_opp) begin
         if (grant0 || grant1) begin
            shreg_d    = grant1 ? data1 : data0;
            cnt_d      = '0;
            state_d    = SHIFT;
            last_d     = grant1;
            grant_id_d = grant1;
            ack0_d     = grant0;
            ack1_d     = grant1;
         end else begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      end else begin
         shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
         cnt_d   = cnt_q + CW'(1);
      end
   end

   // Rising-edge control state; last resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shreg_q    <= '0;
         last_q     <= 1'b1;
         grant_id_q <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         last_q     <= last_d;
         grant_id_q <= grant_id_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
      end
   end

   // Serial frame outputs decoded from the current rising-edge state.
   always_comb begin
      sdo_d   = (state_q == SHIFT) && shreg_q[WIDTH-1];
      start_d = (state_q == SHIFT) && (cnt_q == '0);
      str_d   = (state_q == SHIFT) && (cnt_q == CNT_LAST);
   end

   // Launch on the falling edge so the chain gets half a cycle of setup before its rising edge.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sdo_q   <= 1'b0;
         start_q <= 1'b0;
         str_q   <= 1'b0;
      end else begin
         sdo_q   <= sdo_d;
         start_q <= start_d;
         str_q   <= str_d;
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign busy     = (state_q == SHIFT);
   assign grant_id = grant_id_q;
   assign sdo      = sdo_q;
   assign start    = start_q;
   assign str      = str_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: directed scenarios followed by random traffic,
// all checked against a frame-queue reference model (one queue entry per serial bit).
module tb_led_frame_scheduler;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         req0 = 1'b0;
   logic         req1 = 1'b0;
   logic [W-1:0] data0 = '0;
   logic [W-1:0] data1 = '0;
   logic         ack0, ack1, sdo, start, str, busy, grant_id;

   led_frame_scheduler #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .req0     (req0),
      .data0    (data0),
      .ack0     (ack0),
      .req1     (req1),
      .data1    (data1),
      .ack1     (ack1),
      .sdo      (sdo),
      .start    (start),
      .str      (str),
      .busy     (busy),
      .grant_id (grant_id)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: queue of expected per-bit outputs; front = bit shown in the current cycle.
   typedef struct packed {
      logic sdo;
      logic start;
      logic str;
      logic gid;
   } ent_t;

   ent_t  exp_q[$];
   logic  m_last = 1'b1;
   logic  a0 = 1'b0;
   logic  a1 = 1'b0;

   // Requester agent and observation counters.
   logic        hold0 = 1'b0;
   logic        hold1 = 1'b0;
   logic [31:0] sdo_hist = '0;
   int          ack0_n = 0;
   int          ack1_n = 0;
   int          busy_n = 0;
   int          str_n = 0;
   int          acks_seen[$];

   task automatic chk1(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %b, expected %b", tag, obs, expv);
      end
   endtask

   task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   // Model decision for the coming rising edge, using the inputs as currently driven.
   task automatic model_edge();
      bit           opp;
      int           g;
      logic [W-1:0] w;
      ent_t         e;
      a0  = 1'b0;
      a1  = 1'b0;
      opp = (exp_q.size() <= 1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (flush) begin
         exp_q.delete();
      end else if (opp) begin
         g = -1;
         if (req0 && req1) g = m_last ? 0 : 1;
         else if (req0)    g = 0;
         else if (req1)    g = 1;
         if (g >= 0) begin
            w = (g == 1) ? data1 : data0;
            for (int i = 0; i < W; i++) begin
               e.sdo   = w[W-1-i];
               e.start = (i == 0);
               e.str   = (i == W-1);
               e.gid   = (g == 1);
               exp_q.push_back(e);
            end
            m_last = (g == 1);
            a0     = (g == 0);
            a1     = (g == 1);
         end
      end
   endtask

   // One clock: model step, check rising-edge outputs, then falling-edge outputs, then requester reaction.
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      chk1("ack0", ack0, a0);
      chk1("ack1", ack1, a1);
      chk1("busy", busy, exp_q.size() > 0);
      if (exp_q.size() > 0) chk1("grant_id", grant_id, exp_q[0].gid);
      if (ack0 === 1'b1) begin ack0_n++; acks_seen.push_back(0); end
      if (ack1 === 1'b1) begin ack1_n++; acks_seen.push_back(1); end
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         chk1("sdo", sdo, exp_q[0].sdo);
         chk1("start", start, exp_q[0].start);
         chk1("str", str, exp_q[0].str);
      end else begin
         chk1("sdo_idle", sdo, 1'b0);
         chk1("start_idle", start, 1'b0);
         chk1("str_idle", str, 1'b0);
      end
      if (str === 1'b1) str_n++;
      sdo_hist = {sdo_hist[30:0], sdo};
      if (a0) begin
         if (hold0) data0 = W'($urandom);
         else       req0 = 1'b0;
      end
      if (a1) begin
         if (hold1) data1 = W'($urandom);
         else       req1 = 1'b0;
      end
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      flush = 1'b0;
      exp_q.delete();
      m_last = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk1({tag, "_sdo"}, sdo, 1'b0);
      chk1({tag, "_start"}, start, 1'b0);
      chk1({tag, "_str"}, str, 1'b0);
      chk1({tag, "_ack0"}, ack0, 1'b0);
      chk1({tag, "_ack1"}, ack1, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_grant_id"}, grant_id, 1'b0);
   endtask

   initial begin
      // Reset state.
      #12;
      chk_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) tick();

      // Single word: 0xA5C3 from requester 0.
      reset_dut();
      data0  = 16'hA5C3;
      req0   = 1'b1;
      ack0_n = 0;
      busy_n = 0;
      str_n  = 0;
      repeat (18) tick();
      chkn("single_sdo_seq", {16'h0, sdo_hist[17:2]}, 32'h0000A5C3);
      chkn("single_ack0_count", ack0_n, 1);
      chkn("single_busy_cycles", busy_n, 16);
      chkn("single_str_count", str_n, 1);

      // Tie right after reset: requester 0 first, then 1 back-to-back.
      reset_dut();
      data0 = 16'h00FF;
      data1 = 16'hFF00;
      req0  = 1'b1;
      req1  = 1'b1;
      ack0_n = 0;
      ack1_n = 0;
      acks_seen.delete();
      repeat (34) tick();
      chkn("tie_ack0_count", ack0_n, 1);
      chkn("tie_ack1_count", ack1_n, 1);
      chkn("tie_ack_events", acks_seen.size(), 2);
      if (acks_seen.size() >= 2) begin
         chkn("tie_first_grant", acks_seen[0], 0);
         chkn("tie_second_grant", acks_seen[1], 1);
      end

      // Continuous requester 1: one frame every W cycles.
      hold1  = 1'b1;
      data1  = W'($urandom);
      req1   = 1'b1;
      ack1_n = 0;
      repeat (4 * W) tick();
      hold1 = 1'b0;
      req1  = 1'b0;
      repeat (W + 1) tick();
      chkn("cont_ack1_count", ack1_n, 4);

      // Flush at cnt=7 of an all-ones frame.
      data0 = 16'hFFFF;
      req0  = 1'b1;
      str_n = 0;
      tick();
      repeat (7) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (20) tick();
      chkn("flush_no_str", str_n, 0);
      data0  = W'($urandom);
      req0   = 1'b1;
      ack0_n = 0;
      repeat (W + 2) tick();
      chkn("flush_fresh_ack0", ack0_n, 1);

      // Asynchronous reset in the middle of a frame at cnt=10.
      data0 = W'($urandom);
      req0  = 1'b1;
      tick();
      repeat (10) tick();
      rst_n = 1'b0;
      req0  = 1'b0;
      #1;
      chk_all_zero("midreset");
      exp_q.delete();
      m_last = 1'b1;
      @(posedge clk);
      #1;
      chk_all_zero("midreset_held");
      rst_n = 1'b1;
      data0 = W'($urandom);
      data1 = W'($urandom);
      req0  = 1'b1;
      req1  = 1'b1;
      acks_seen.delete();
      repeat (2 * W + 2) tick();
      chkn("midreset_tie_events", acks_seen.size(), 2);
      if (acks_seen.size() >= 1) chkn("midreset_tie_first", acks_seen[0], 0);

      // Fairness: 0, 0, then a tie goes to 1.
      for (int k = 0; k < 2; k++) begin
         data0 = W'($urandom);
         req0  = 1'b1;
         repeat (W + 1) tick();
      end
      data0 = W'($urandom);
      data1 = W'($urandom);
      req0  = 1'b1;
      req1  = 1'b1;
      acks_seen.delete();
      repeat (2 * W + 2) tick();
      chkn("fair_tie_events", acks_seen.size(), 2);
      if (acks_seen.size() >= 1) chkn("fair_tie_first", acks_seen[0], 1);

      // Random traffic with occasional flush.
      for (int n = 0; n < 800; n++) begin
         if (!req0 && ($urandom_range(0, 3) == 0)) begin
            data0 = W'($urandom);
            req0  = 1'b1;
         end
         if (!req1 && ($urandom_range(0, 3) == 0)) begin
            data1 = W'($urandom);
            req1  = 1'b1;
         end
         flush = ($urandom_range(0, 49) == 0);
         tick();
      end
      flush = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      repeat (2 * W + 2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
